led_activity_monitor: RTL and testbench



---
 rtl/led_activity_monitor.sv | 147 ++++++++++++++
 tb/tb_led_activity_monitor.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/led_activity_monitor.sv
// led_activity_monitor: per-channel activity LEDs with pulse stretching and a
// forced dark gap after each flash, plus a free-running heartbeat.
//
// Ports:
//   clk_sys    system clock
//   reset_n    asynchronous active-low reset
//   enable     global enable for the activity channels (heartbeat ignores it)
//   act_in     raw asynchronous monitored lines, idle level from IDLE_MASK
//   led_act    stretched activity LED drive, 1 = lit
//   act_pulse  one-cycle strobe per idle->active transition
//   heartbeat  heartbeat LED drive, MSB of an HB_W-bit counter
module led_activity_monitor #(
  parameter int unsigned N_CH           = 2,
  parameter logic [31:0] IDLE_MASK      = 32'hFFFF_FFFF,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STRETCH_CYCLES = 1048576,
  parameter int unsigned GAP_CYCLES     = 262144,
  parameter int unsigned HB_W           = 24
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [N_CH-1:0] act_in,
  output logic [N_CH-1:0] led_act,
  output logic [N_CH-1:0] act_pulse,
  output logic            heartbeat
);

  localparam int unsigned CNT_MAX = (STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD     = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic IDLE_LVL = IDLE_MASK[i];

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   active;
    logic                   prev_active_q;
    logic                   pulse_q;
    logic                   led_q;
    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;

    // Synchroniser; reset loads the idle level so release never looks like activity
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        sync_q <= {SYNC_STAGES{IDLE_LVL}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], act_in[i]};
      end
    end

    assign active = (sync_q[SYNC_STAGES-1] != IDLE_LVL);

    // Next-state: IDLE -> ON (stretch, retriggerable) -> GAP (activity ignored) -> IDLE
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!enable) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (active) begin
              state_d = ST_ON;
              cnt_d   = STRETCH_LOAD;
            end
          end
          ST_ON: begin
            if (active) begin
              cnt_d = STRETCH_LOAD;
            end else if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else if (GAP_CYCLES == 0) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = ST_GAP;
              cnt_d   = GAP_LOAD;
            end
          end
          ST_GAP: begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else begin
              state_d = ST_IDLE;
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // State, edge history and registered outputs; led follows the next state so
    // it rises on the same edge as act_pulse
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        state_q       <= ST_IDLE;
        cnt_q         <= '0;
        prev_active_q <= 1'b0;
        pulse_q       <= 1'b0;
        led_q         <= 1'b0;
      end else begin
        state_q       <= state_d;
        cnt_q         <= cnt_d;
        prev_active_q <= active;
        pulse_q       <= enable & active & ~prev_active_q;
        led_q         <= (state_d == ST_ON);
      end
    end

    assign led_act[i]   = led_q;
    assign act_pulse[i] = pulse_q;
  end

  logic [HB_W-1:0] hb_cnt_q;
  logic [HB_W-1:0] hb_cnt_d;
  logic            hb_q;

  assign hb_cnt_d = hb_cnt_q + HB_W'(1);

  // Free-running heartbeat; output registered from the next count's MSB
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_cnt_d[HB_W-1];
    end
  end

  assign heartbeat = hb_q;

endmodule

// File: tb/tb_led_activity_monitor.sv
// Directed bench for led_activity_monitor with short stretch/gap/heartbeat
// parameters; edge k is the k-th rising edge after inputs are applied.
module tb_led_activity_monitor;

  logic       clk_sys;
  logic       reset_n;
  logic       enable;
  logic [1:0] act_in;
  logic [1:0] led_act;
  logic [1:0] act_pulse;
  logic       heartbeat;

  int n_cmp = 0;
  int n_err = 0;

  led_activity_monitor #(
    .N_CH          (2),
    .IDLE_MASK     (32'h0000_0003),
    .SYNC_STAGES   (2),
    .STRETCH_CYCLES(8),
    .GAP_CYCLES    (4),
    .HB_W          (4)
  ) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .enable   (enable),
    .act_in   (act_in),
    .led_act  (led_act),
    .act_pulse(act_pulse),
    .heartbeat(heartbeat)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] e_led;
    logic [1:0] e_pls;
    logic [1:0] e_hb;

    // Reset with inputs at the active level
    reset_n = 1'b0;
    enable  = 1'b1;
    act_in  = 2'b00;
    repeat (3) step();
    chk("rst led", led_act, 2'b00);
    chk("rst pulse", act_pulse, 2'b00);
    chk("rst hb", {1'b0, heartbeat}, 2'b00);

    // Release with idle inputs; heartbeat toggles every 8 edges
    reset_n = 1'b1;
    act_in  = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      step();
      e_hb = (((k / 8) % 2) == 1) ? 2'b01 : 2'b00;
      chk($sformatf("t1 hb k=%0d", k), {1'b0, heartbeat}, e_hb);
      chk($sformatf("t1 led k=%0d", k), led_act, 2'b00);
      chk($sformatf("t1 pulse k=%0d", k), act_pulse, 2'b00);
    end

    // Single one-cycle low on channel 0
    for (int k = 1; k <= 16; k++) begin
      act_in = (k == 1) ? 2'b10 : 2'b11;
      step();
      e_led = (k >= 3 && k <= 10) ? 2'b01 : 2'b00;
      e_pls = (k == 3) ? 2'b01 : 2'b00;
      chk($sformatf("t2 led k=%0d", k), led_act, e_led);
      chk($sformatf("t2 pulse k=%0d", k), act_pulse, e_pls);
    end

    // Retrigger: lows before edges 1, 6, 11
    for (int k = 1; k <= 26; k++) begin
      act_in = (k == 1 || k == 6 || k == 11) ? 2'b10 : 2'b11;
      step();
      e_led = (k >= 3 && k <= 20) ? 2'b01 : 2'b00;
      e_pls = (k == 3 || k == 8 || k == 13) ? 2'b01 : 2'b00;
      chk($sformatf("t3 led k=%0d", k), led_act, e_led);
      chk($sformatf("t3 pulse k=%0d", k), act_pulse, e_pls);
    end

    // Channel 1 flash, then a low that lands in its GAP
    for (int k = 1; k <= 30; k++) begin
      act_in = (k == 1 || k == 10) ? 2'b01 : 2'b11;
      step();
      e_led = (k >= 3 && k <= 10) ? 2'b10 : 2'b00;
      e_pls = (k == 3 || k == 12) ? 2'b10 : 2'b00;
      chk($sformatf("t4 led k=%0d", k), led_act, e_led);
      chk($sformatf("t4 pulse k=%0d", k), act_pulse, e_pls);
    end

    // Both channels held active for 20 cycles
    for (int k = 1; k <= 34; k++) begin
      act_in = (k <= 20) ? 2'b00 : 2'b11;
      step();
      e_led = (k >= 3 && k <= 29) ? 2'b11 : 2'b00;
      e_pls = (k == 3) ? 2'b11 : 2'b00;
      chk($sformatf("t5 led k=%0d", k), led_act, e_led);
      chk($sformatf("t5 pulse k=%0d", k), act_pulse, e_pls);
    end

    // Enable dropped mid-ON (edges 6..9) with channel 0 held active
    for (int k = 1; k <= 29; k++) begin
      act_in = (k <= 14) ? 2'b10 : 2'b11;
      enable = (k >= 6 && k <= 9) ? 1'b0 : 1'b1;
      step();
      e_led = ((k >= 3 && k <= 5) || (k >= 10 && k <= 23)) ? 2'b01 : 2'b00;
      e_pls = (k == 3) ? 2'b01 : 2'b00;
      chk($sformatf("t6 led k=%0d", k), led_act, e_led);
      chk($sformatf("t6 pulse k=%0d", k), act_pulse, e_pls);
    end
    enable = 1'b1;

    // Asynchronous reset while channel 0 is lit
    for (int k = 1; k <= 5; k++) begin
      act_in = (k == 1) ? 2'b10 : 2'b11;
      step();
    end
    chk("t7 led before rst", led_act, 2'b01);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t7 led in rst", led_act, 2'b00);
    chk("t7 pulse in rst", act_pulse, 2'b00);
    chk("t7 hb in rst", {1'b0, heartbeat}, 2'b00);
    repeat (2) step();
    reset_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("t7 led k=%0d", k), led_act, 2'b00);
      chk($sformatf("t7 pulse k=%0d", k), act_pulse, 2'b00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
